// File: rtl/ysyx_24110015_pkg.sv
// Shared constants, register-select type and FSM encodings for the CLINT.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ysyx_24110015_pkg;

    // Register offsets relative to CLINT_BASE
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        SEL_CMP_LO  = 3'd0,
        SEL_CMP_HI  = 3'd1,
        SEL_TIME_LO = 3'd2,
        SEL_TIME_HI = 3'd3,
        SEL_NONE    = 3'd4
    } reg_sel_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Word decode: only offset[15:2] takes part, byte lane bits are ignored.
    function automatic reg_sel_e clint_decode(input logic [13:0] word_off);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word_off == CLINT_MTIMECMP_LO[15:2]) sel = SEL_CMP_LO;
        if (word_off == CLINT_MTIMECMP_HI[15:2]) sel = SEL_CMP_HI;
        if (word_off == CLINT_MTIME_LO[15:2])    sel = SEL_TIME_LO;
        if (word_off == CLINT_MTIME_HI[15:2])    sel = SEL_TIME_HI;
        return sel;
    endfunction

    function automatic logic [31:0] clint_read(input reg_sel_e sel,
                                               input logic [63:0] mtime,
                                               input logic [63:0] mtimecmp);
        logic [31:0] val;
        val = 32'h0;
        case (sel)
            SEL_CMP_LO:  val = mtimecmp[31:0];
            SEL_CMP_HI:  val = mtimecmp[63:32];
            SEL_TIME_LO: val = mtime[31:0];
            SEL_TIME_HI: val = mtime[63:32];
            default:     val = 32'h0;
        endcase
        return val;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] dat,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = dat[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_24110015_clint_timer.sv
// Prescaled 64-bit mtime, mtimecmp and registered mtip with a byte-strobed write port.
// Latency: writes land on the next edge; mtip lags the compare by one cycle.
// Backpressure: none, the write port is always accepted.
// Ports: clk/rst; wr_en_i, wr_sel_i (reg_sel_e encoding), wr_dat_i, wr_strb_i;
//        mtime_o, mtimecmp_o (current register values), mtip_o.
module ysyx_24110015_clint_timer
    import ysyx_24110015_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [2:0]  wr_sel_i,
    input  logic [31:0] wr_dat_i,
    input  logic [3:0]  wr_strb_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic        mtip_o
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             mtip_q;
    logic             tick;
    reg_sel_e         wr_sel;

    assign wr_sel = reg_sel_e'(wr_sel_i);
    assign tick   = (div_cnt_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        // A software write to mtime replaces the increment for that cycle;
        // the prescaler keeps running so the tick cadence is undisturbed.
        if (wr_en_i) begin
            case (wr_sel)
                SEL_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], byte_merge(mtimecmp_q[31:0], wr_dat_i, wr_strb_i)};
                SEL_CMP_HI:  mtimecmp_d = {byte_merge(mtimecmp_q[63:32], wr_dat_i, wr_strb_i), mtimecmp_q[31:0]};
                SEL_TIME_LO: mtime_d    = {mtime_q[63:32], byte_merge(mtime_q[31:0], wr_dat_i, wr_strb_i)};
                SEL_TIME_HI: mtime_d    = {byte_merge(mtime_q[63:32], wr_dat_i, wr_strb_i), mtime_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= (mtime_q >= mtimecmp_q);
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = mtimecmp_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/ysyx_24110015_clint.sv
// AXI4 slave CLINT: independent single-outstanding read and write FSMs around the timer.
// Latency: rvalid one cycle after ar handshake; wready one cycle after aw; bvalid one after wlast.
// Backpressure: arready/awready low while a burst is in flight; r/b outputs hold until accepted.
// Ports: clk/rst; AXI4 slave aw/w/b/ar/r channels (32-bit data, ID_W-bit ids); mtip_o.
module ysyx_24110015_clint
    import ysyx_24110015_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned ID_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    // write address
    input  logic            axi_awvalid_i,
    output logic            axi_awready_o,
    input  logic [31:0]     axi_awaddr_i,
    input  logic [ID_W-1:0] axi_awid_i,
    input  logic [7:0]      axi_awlen_i,
    input  logic [2:0]      axi_awsize_i,
    input  logic [1:0]      axi_awburst_i,
    // write data
    input  logic            axi_wvalid_i,
    output logic            axi_wready_o,
    input  logic [31:0]     axi_wdata_i,
    input  logic [3:0]      axi_wstrb_i,
    input  logic            axi_wlast_i,
    // write response
    output logic            axi_bvalid_o,
    input  logic            axi_bready_i,
    output logic [1:0]      axi_bresp_o,
    output logic [ID_W-1:0] axi_bid_o,
    // read address
    input  logic            axi_arvalid_i,
    output logic            axi_arready_o,
    input  logic [31:0]     axi_araddr_i,
    input  logic [ID_W-1:0] axi_arid_i,
    input  logic [7:0]      axi_arlen_i,
    input  logic [2:0]      axi_arsize_i,
    input  logic [1:0]      axi_arburst_i,
    // read data
    output logic            axi_rvalid_o,
    input  logic            axi_rready_i,
    output logic [31:0]     axi_rdata_o,
    output logic [1:0]      axi_rresp_o,
    output logic [ID_W-1:0] axi_rid_o,
    output logic            axi_rlast_o,
    // interrupt
    output logic            mtip_o
);

    logic [63:0] mtime, mtimecmp;
    logic [31:0] ar_off, aw_off;
    reg_sel_e    ar_sel, aw_sel;

    assign ar_off = axi_araddr_i - CLINT_BASE;
    assign aw_off = axi_awaddr_i - CLINT_BASE;
    assign ar_sel = clint_decode(ar_off[15:2]);
    assign aw_sel = clint_decode(aw_off[15:2]);

    // Size and burst type do not matter: every beat targets the latched word.
    logic unused_ok;
    assign unused_ok = ^{ar_off[31:16], ar_off[1:0], aw_off[31:16], aw_off[1:0],
                         axi_arsize_i, axi_arburst_i, axi_awsize_i, axi_awburst_i, axi_awlen_i};

    // ---------------- read channel ----------------
    r_state_e        r_state_q, r_state_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [7:0]      rbeats_q, rbeats_d;
    reg_sel_e        rsel_q, rsel_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rbeats_d  = rbeats_q;
        rsel_d    = rsel_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid_i) begin
                    r_state_d = R_DATA;
                    rid_d     = axi_arid_i;
                    rbeats_d  = axi_arlen_i;
                    rsel_d    = ar_sel;
                    rdata_d   = clint_read(ar_sel, mtime, mtimecmp);
                    rresp_d   = (ar_sel == SEL_NONE) ? AXI_SLVERR : AXI_OKAY;
                end
            end
            R_DATA: begin
                if (axi_rready_i) begin
                    if (rbeats_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rbeats_d = rbeats_q - 8'd1;
                        rdata_d  = clint_read(rsel_q, mtime, mtimecmp);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            rbeats_q  <= 8'd0;
            rsel_q    <= SEL_NONE;
            rdata_q   <= 32'h0;
            rresp_q   <= AXI_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            rbeats_q  <= rbeats_d;
            rsel_q    <= rsel_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign axi_arready_o = (r_state_q == R_IDLE);
    assign axi_rvalid_o  = (r_state_q == R_DATA);
    assign axi_rlast_o   = (r_state_q == R_DATA) && (rbeats_q == 8'd0);
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rid_o     = rid_q;

    // ---------------- write channel ----------------
    w_state_e        w_state_q, w_state_d;
    logic [ID_W-1:0] bid_q, bid_d;
    reg_sel_e        wsel_q, wsel_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            wr_en;

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        wsel_d    = wsel_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid_i) begin
                    w_state_d = W_DATA;
                    bid_d     = axi_awid_i;
                    wsel_d    = aw_sel;
                    // Response is fixed by the address, so SLVERR covers every beat.
                    bresp_d   = (aw_sel == SEL_NONE) ? AXI_SLVERR : AXI_OKAY;
                end
            end
            W_DATA: begin
                if (axi_wvalid_i && axi_wlast_i) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (axi_bready_i) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            wsel_q    <= SEL_NONE;
            bresp_q   <= AXI_OKAY;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            wsel_q    <= wsel_d;
            bresp_q   <= bresp_d;
        end
    end

    assign wr_en         = (w_state_q == W_DATA) && axi_wvalid_i && (wsel_q != SEL_NONE);
    assign axi_awready_o = (w_state_q == W_IDLE);
    assign axi_wready_o  = (w_state_q == W_DATA);
    assign axi_bvalid_o  = (w_state_q == W_RESP);
    assign axi_bresp_o   = bresp_q;
    assign axi_bid_o     = bid_q;

    ysyx_24110015_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_sel_i   (wsel_q),
        .wr_dat_i   (axi_wdata_i),
        .wr_strb_i  (axi_wstrb_i),
        .mtime_o    (mtime),
        .mtimecmp_o (mtimecmp),
        .mtip_o     (mtip_o)
    );

endmodule
